// File: rtl/alu_pkg.sv
// Shared definitions for the 64-bit registered ALU: opcode encoding and datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 64;

  // Opcodes 001 and 111 are reserved and produce a zero result.
  typedef enum logic [2:0] {
    ALU_PASS_B = 3'b000,
    ALU_ADD    = 3'b010,
    ALU_SUB    = 3'b011,
    ALU_AND    = 3'b100,
    ALU_OR     = 3'b101,
    ALU_XOR    = 3'b110
  } alu_op_e;

endpackage

// File: rtl/alu64_reg_if.sv
// Operand/result bundle between the issue logic (master) and the execute-stage ALU (slave).
interface alu64_reg_if;
  import alu_pkg::*;

  logic [ALU_WIDTH-1:0] A;
  logic [ALU_WIDTH-1:0] B;
  logic [2:0]           control;
  logic                 in_valid;
  logic                 out_valid;
  logic [ALU_WIDTH-1:0] ALU_outputBus;
  logic                 carry_out;
  logic                 negative;
  logic                 overflow;
  logic                 zero;

  modport master (
    output A, B, control, in_valid,
    input  out_valid, ALU_outputBus, carry_out, negative, overflow, zero
  );

  modport slave (
    input  A, B, control, in_valid,
    output out_valid, ALU_outputBus, carry_out, negative, overflow, zero
  );

endinterface

// File: rtl/alu_bit_slice.sv
// One bit of the ALU: conditional B inversion into a full adder, plus the per-bit op mux.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [2:0] sel,
  output logic       cout,
  output logic       result
);

  logic b_eff;
  logic sum;

  // The adder always runs (B inverted on odd opcodes) so the flags exist for every op.
  assign b_eff = b ^ sel[0];
  assign sum   = a ^ b_eff ^ cin;
  assign cout  = (a & b_eff) | (a & cin) | (b_eff & cin);

  always_comb begin
    result = 1'b0;
    case (sel)
      ALU_PASS_B: result = b;
      ALU_ADD:    result = sum;
      ALU_SUB:    result = sum;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      default:    result = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu64_reg.sv
// 64-bit ripple-carry ALU with condition flags and a single registered output stage.
module alu64_reg
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  alu64_reg_if.slave  bus
);

  logic [ALU_WIDTH:0]   carry;
  logic [ALU_WIDTH-1:0] result_next;
  logic [15:0]          nor_level;
  logic [3:0]           and_level;
  logic                 zero_next;
  logic                 overflow_next;

  assign carry[0] = bus.control[0];

  for (genvar i = 0; i < ALU_WIDTH; i++) begin : g_slice
    alu_bit_slice u_slice (
      .a      (bus.A[i]),
      .b      (bus.B[i]),
      .cin    (carry[i]),
      .sel    (bus.control),
      .cout   (carry[i+1]),
      .result (result_next[i])
    );
  end

  // Zero detect as a shallow tree: 16 nibble NORs, four 4-input ANDs, one final AND.
  for (genvar g = 0; g < 16; g++) begin : g_nor4
    assign nor_level[g] = ~|result_next[4*g +: 4];
  end

  for (genvar h = 0; h < 4; h++) begin : g_and4
    assign and_level[h] = &nor_level[4*h +: 4];
  end

  assign zero_next     = &and_level;
  assign overflow_next = carry[ALU_WIDTH] ^ carry[ALU_WIDTH-1];

  // Result and flags load only on valid cycles; out_valid simply follows in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid     <= 1'b0;
      bus.ALU_outputBus <= '0;
      bus.carry_out     <= 1'b0;
      bus.negative      <= 1'b0;
      bus.overflow      <= 1'b0;
      bus.zero          <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.ALU_outputBus <= result_next;
        bus.carry_out     <= carry[ALU_WIDTH];
        bus.negative      <= result_next[ALU_WIDTH-1];
        bus.overflow      <= overflow_next;
        bus.zero          <= zero_next;
      end
    end
  end

endmodule

// File: tb/tb_alu64_reg.sv
// Self-checking bench for alu64_reg: directed vector table, reset/valid/hold sequences,
// and randomized operations compared against an arithmetic reference model.
module tb_alu64_reg;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  alu64_reg_if bus ();

  alu64_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] res;
    logic        c;
    logic        n;
    logic        v;
    logic        z;
  } exp_t;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  ctl;
    logic [63:0] res;
    logic        c;
    logic        n;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs [12];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Flags come from A + (B ^ {64{ctl[0]}}) + ctl[0]; overflow compares carry into and out of bit 63.
  function automatic exp_t ref_model(input logic [63:0] a, input logic [63:0] b,
                                     input logic [2:0] ctl);
    exp_t        r;
    logic [64:0] full;
    logic [63:0] low;
    logic [63:0] bx;
    logic        cin;
    cin  = ctl[0];
    bx   = cin ? ~b : b;
    full = {1'b0, a} + {1'b0, bx} + 65'(cin);
    low  = {1'b0, a[62:0]} + {1'b0, bx[62:0]} + 64'(cin);
    case (ctl)
      3'd0:    r.res = b;
      3'd2:    r.res = a + b;
      3'd3:    r.res = a - b;
      3'd4:    r.res = a & b;
      3'd5:    r.res = a | b;
      3'd6:    r.res = a ^ b;
      default: r.res = 64'd0;
    endcase
    r.c = full[64];
    r.v = full[64] ^ low[63];
    r.n = r.res[63];
    r.z = (r.res == 64'd0);
    return r;
  endfunction

  task automatic apply_stimulus(input logic [63:0] a, input logic [63:0] b,
                                input logic [2:0] ctl, input logic valid, input logic rst);
    @(negedge clk);
    bus.A        = a;
    bus.B        = b;
    bus.control  = ctl;
    bus.in_valid = valid;
    reset        = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic check_all(input string name, input logic exp_valid, input exp_t e);
    check_output({name, " out_valid"}, 64'(bus.out_valid), 64'(exp_valid));
    check_output({name, " result"},    bus.ALU_outputBus,  e.res);
    check_output({name, " carry"},     64'(bus.carry_out), 64'(e.c));
    check_output({name, " negative"},  64'(bus.negative),  64'(e.n));
    check_output({name, " overflow"},  64'(bus.overflow),  64'(e.v));
    check_output({name, " zero"},      64'(bus.zero),      64'(e.z));
  endtask

  initial begin
    exp_t        e;
    exp_t        cleared;
    exp_t        hold;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [2:0]  rc;
    logic        rv;

    n_checks = 0;
    n_fails  = 0;
    cleared  = '{res: 64'd0, c: 1'b0, n: 1'b0, v: 1'b0, z: 1'b0};

    vecs[0]  = '{64'd300, 64'd250, 3'd0, 64'd250, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{64'd300, 64'd250, 3'd1, 64'd0,   1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{64'd300, 64'd250, 3'd2, 64'd550, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{64'd300, 64'd250, 3'd3, 64'd50,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{64'd300, 64'd250, 3'd4, 64'd40,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{64'd300, 64'd250, 3'd5, 64'd510, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{64'd300, 64'd250, 3'd6, 64'd470, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{64'd300, 64'd250, 3'd7, 64'd0,   1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{64'd100, 64'd120, 3'd3, 64'hFFFF_FFFF_FFFF_FFEC, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 3'd2,
                 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{64'd0, 64'd0, 3'd2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{64'd0, 64'd0, 3'd3, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1};

    bus.A        = 64'd0;
    bus.B        = 64'd0;
    bus.control  = 3'd0;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 1'b0, cleared);

    // Directed vectors issued back to back, one per cycle.
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].ctl, 1'b1, 1'b0);
      e = '{res: vecs[i].res, c: vecs[i].c, n: vecs[i].n, v: vecs[i].v, z: vecs[i].z};
      check_all($sformatf("vec%0d", i), 1'b1, e);
    end

    // Burst interrupted by reset, then idle, then the first valid op after reset.
    apply_stimulus(64'd7, 64'd5, 3'd2, 1'b1, 1'b0);
    check_all("burst1", 1'b1, ref_model(64'd7, 64'd5, 3'd2));
    apply_stimulus(64'd7, 64'd5, 3'd3, 1'b1, 1'b0);
    check_all("burst2", 1'b1, ref_model(64'd7, 64'd5, 3'd3));
    apply_stimulus(64'd9, 64'd9, 3'd6, 1'b1, 1'b1);
    check_all("midreset", 1'b0, cleared);
    apply_stimulus(64'd1, 64'd2, 3'd2, 1'b0, 1'b0);
    check_all("idle_after_reset", 1'b0, cleared);
    apply_stimulus(64'd1, 64'd2, 3'd2, 1'b1, 1'b0);
    check_all("first_after_reset", 1'b1, ref_model(64'd1, 64'd2, 3'd2));

    // Hold: invalid cycles must not disturb the registered result or flags.
    apply_stimulus(64'd300, 64'd250, 3'd2, 1'b1, 1'b0);
    hold = '{res: 64'd550, c: 1'b0, n: 1'b0, v: 1'b0, z: 1'b0};
    check_all("hold_load", 1'b1, hold);
    apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'd3, 1'b0, 1'b0);
    check_all("hold1", 1'b0, hold);
    apply_stimulus(64'd0, 64'd0, 3'd1, 1'b0, 1'b0);
    check_all("hold2", 1'b0, hold);

    for (int i = 0; i < 300; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: ra = 64'd0;
        1: rb = ra;
        2: rb = 64'h8000_0000_0000_0000;
        3: ra = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      rc = 3'($urandom_range(0, 7));
      rv = (i == 0) || ($urandom_range(0, 3) != 0);
      if (rv) hold = ref_model(ra, rb, rc);
      apply_stimulus(ra, rb, rc, rv, 1'b0);
      check_all($sformatf("rand%0d op%0d", i, rc), rv, hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
